// File: rtl/wb_unit.sv
// wb_unit: memory-access and write-back stage of the pipeline.
// Holds the M and WB pipeline registers and runs a small IDLE/ACCESS FSM
// that talks to the data memory and stalls the upstream stages while a
// load or store is waiting for mem_ack. A wait counter bounds each access.
// A timed-out access is dropped and recorded in a sticky error flag.
module wb_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_RegWrite,
  input  logic        ex_mem_to_reg,
  input  logic        ex_reg_to_mem,
  input  logic [3:0]  ex_reg_rd,
  input  logic [15:0] ex_alu_result,
  input  logic [15:0] ex_store_data,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        RegWrite_out,
  output logic [3:0]  reg_rd_wb,
  output logic [15:0] reg_rd_data,
  output logic [3:0]  EX_MEM_reg_rd,
  output logic [3:0]  MEM_WB_reg_rd,
  output logic        mem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_next;

  logic        m_valid, m_regwrite, m_mem_to_reg, m_reg_to_mem;
  logic [3:0]  m_rd;
  logic [15:0] m_alu_result, m_store_data;

  logic        wb_valid, wb_regwrite, wb_reg_to_mem;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;

  logic [3:0]  wait_cnt;
  logic [3:0]  wait_inc;

  logic        in_access, advance, timeout, ex_is_mem;

  assign in_access = (state == ACCESS);
  assign stall     = in_access & ~mem_ack;
  assign advance   = ~stall;
  assign ex_is_mem = ex_valid & (ex_mem_to_reg | ex_reg_to_mem);
  assign wait_inc  = wait_cnt + 4'd1;
  // An unacked cycle that would bring the counter to 15 ends the access,
  // so mem_req is held for at most 15 cycles; an ack in that cycle still wins.
  assign timeout   = in_access & ~mem_ack & (wait_inc == 4'd15);

  assign RegWrite_out  = wb_valid & wb_regwrite & ~wb_reg_to_mem & (wb_rd != 4'd0);
  assign reg_rd_wb     = wb_rd;
  assign reg_rd_data   = wb_data;
  assign EX_MEM_reg_rd = (m_valid & m_regwrite) ? m_rd : 4'd0;
  assign MEM_WB_reg_rd = RegWrite_out ? wb_rd : 4'd0;

  // Next-state and memory-port decode; ACCESS with ack can chain straight into the next op.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 16'd0;
    mem_wdata  = 16'd0;
    case (state)
      IDLE: begin
        state_next = ex_is_mem ? ACCESS : IDLE;
      end
      ACCESS: begin
        mem_req   = 1'b1;
        mem_we    = m_reg_to_mem;
        mem_addr  = m_alu_result;
        mem_wdata = m_store_data;
        if (mem_ack)
          state_next = ex_is_mem ? ACCESS : IDLE;
        else if (timeout)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and wait counter; the counter restarts whenever a new op is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_next;
      if (advance || timeout)
        wait_cnt <= 4'd0;
      else
        wait_cnt <= wait_inc;
    end
  end

  // M register: loads from EX whenever the pipe moves, invalidated on timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid      <= 1'b0;
      m_regwrite   <= 1'b0;
      m_mem_to_reg <= 1'b0;
      m_reg_to_mem <= 1'b0;
      m_rd         <= 4'd0;
      m_alu_result <= 16'd0;
      m_store_data <= 16'd0;
    end else if (advance) begin
      m_valid      <= ex_valid;
      m_regwrite   <= ex_RegWrite;
      m_mem_to_reg <= ex_mem_to_reg;
      m_reg_to_mem <= ex_reg_to_mem;
      m_rd         <= ex_reg_rd;
      m_alu_result <= ex_alu_result;
      m_store_data <= ex_store_data;
    end else if (timeout) begin
      m_valid <= 1'b0;
    end
  end

  // WB register: takes M when the access completes (or no access), else a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_regwrite   <= 1'b0;
      wb_reg_to_mem <= 1'b0;
      wb_rd         <= 4'd0;
      wb_data       <= 16'd0;
    end else if (advance) begin
      wb_valid      <= m_valid;
      wb_regwrite   <= m_regwrite;
      wb_reg_to_mem <= m_reg_to_mem;
      wb_rd         <= m_rd;
      wb_data       <= (in_access && m_mem_to_reg && !m_reg_to_mem) ? mem_rdata : m_alu_result;
    end else begin
      wb_valid <= 1'b0;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mem_err <= 1'b0;
    else if (timeout)
      mem_err <= 1'b1;
  end

endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: bench for wb_unit.
// Instructions are listed as transactions with a chosen ack delay; a
// schedule model turns that list into per-cycle expected outputs using
// the occupancy of each instruction in the memory stage.
module tb_wb_unit;

  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_RegWrite, ex_mem_to_reg, ex_reg_to_mem;
  logic [3:0]  ex_reg_rd;
  logic [15:0] ex_alu_result, ex_store_data;
  logic        stall, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        RegWrite_out;
  logic [3:0]  reg_rd_wb;
  logic [15:0] reg_rd_data;
  logic [3:0]  EX_MEM_reg_rd, MEM_WB_reg_rd;
  logic        mem_err;

  wb_unit dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_to_mem(ex_reg_to_mem),
    .ex_reg_rd(ex_reg_rd), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .RegWrite_out(RegWrite_out), .reg_rd_wb(reg_rd_wb), .reg_rd_data(reg_rd_data),
    .EX_MEM_reg_rd(EX_MEM_reg_rd), .MEM_WB_reg_rd(MEM_WB_reg_rd), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // One instruction; d = wait cycles before ack, 15 means never acked.
  typedef struct {
    logic        v, rw, ld, st;
    logic [3:0]  rd;
    logic [15:0] alu, sd, rdata;
    int          d;
  } instr_t;

  instr_t prog[$];

  logic        e_stall[MAXC], e_req[MAXC], e_we[MAXC], e_rw[MAXC], e_err[MAXC];
  logic [15:0] e_addr[MAXC], e_wdata[MAXC], e_data[MAXC];
  logic [3:0]  e_rd[MAXC], e_exmem[MAXC], e_memwb[MAXC];
  int          drive_idx[MAXC];
  logic        ack_at[MAXC];
  logic [15:0] rdata_at[MAXC];
  int          ncyc;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int check_mode = 0;
  bit pin_model = 1'b0;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Schedule model: instruction i is taken at cycle t_i, sits in M for occ cycles,
  // writes back in cycle t_i+occ+1; the next one is taken at t_i+occ.
  task automatic buildModel();
    int t;
    int start;
    int err_from;
    t = 0;
    start = 0;
    err_from = MAXC;
    for (int c = 0; c < MAXC; c++) begin
      e_stall[c] = 0; e_req[c] = 0; e_we[c] = 0; e_rw[c] = 0; e_err[c] = 0;
      e_addr[c] = 0; e_wdata[c] = 0; e_data[c] = 0;
      e_rd[c] = 0; e_exmem[c] = 0; e_memwb[c] = 0;
      drive_idx[c] = -1; ack_at[c] = 0; rdata_at[c] = 16'($urandom);
    end
    for (int i = 0; i < prog.size(); i++) begin
      instr_t x;
      bit mem, tmo;
      int acc, occ, mvalid;
      x = prog[i];
      mem = x.v && (x.ld || x.st);
      tmo = mem && (x.d >= 15);
      acc = tmo ? 15 : (mem ? x.d + 1 : 0);
      occ = tmo ? 16 : (mem ? x.d + 1 : 1);
      mvalid = tmo ? 15 : occ;
      for (int c = start; c <= t; c++) drive_idx[c] = i;
      for (int k = 1; k <= mvalid; k++)
        if (x.v && x.rw) e_exmem[t + k] = x.rd;
      for (int k = 1; k <= acc; k++) begin
        e_req[t + k]   = 1;
        e_we[t + k]    = x.st;
        e_addr[t + k]  = x.alu;
        e_wdata[t + k] = x.sd;
        e_stall[t + k] = tmo || (k < acc);
      end
      if (mem && !tmo) begin
        ack_at[t + acc]   = 1;
        rdata_at[t + acc] = x.rdata;
      end
      if (!tmo && x.v && x.rw && !x.st && x.rd != 0) begin
        e_rw[t + occ + 1]    = 1;
        e_rd[t + occ + 1]    = x.rd;
        e_memwb[t + occ + 1] = x.rd;
        e_data[t + occ + 1]  = x.ld ? x.rdata : x.alu;
      end
      if (tmo && (t + 16 < err_from)) err_from = t + 16;
      start = t + 1;
      t = t + occ;
    end
    for (int c = 0; c < MAXC; c++) e_err[c] = (c >= err_from);
    ncyc = t + 3;
  endtask

  task automatic applyStimulus(input int c);
    if (drive_idx[c] >= 0) begin
      instr_t x;
      x = prog[drive_idx[c]];
      ex_valid = x.v; ex_RegWrite = x.rw; ex_mem_to_reg = x.ld; ex_reg_to_mem = x.st;
      ex_reg_rd = x.rd; ex_alu_result = x.alu; ex_store_data = x.sd;
    end else begin
      ex_valid = 0; ex_RegWrite = 1'($urandom); ex_mem_to_reg = 1'($urandom);
      ex_reg_to_mem = 1'($urandom); ex_reg_rd = 4'($urandom);
      ex_alu_result = 16'($urandom); ex_store_data = 16'($urandom);
    end
    mem_ack   = ack_at[c];
    mem_rdata = rdata_at[c];
  endtask

  task automatic runPhase();
    buildModel();
    for (int c = 0; c < ncyc; c++) begin
      cyc = c;
      applyStimulus(c);
      check_mode = 1;
      @(posedge clk); #1;
    end
    check_mode = 0;
  endtask

  task automatic doReset();
    check_mode = 0;
    rst = 1;
    ex_valid = 1; ex_RegWrite = 1; ex_mem_to_reg = 1; ex_reg_to_mem = 0;
    ex_reg_rd = 4'd5; ex_alu_result = 16'h1111; ex_store_data = 16'h2222;
    mem_ack = 1; mem_rdata = 16'h3333;
    @(posedge clk); #1;
    check_mode = 2;
    @(posedge clk); #1;
    check_mode = 0;
    rst = 0;
  endtask

  function automatic instr_t mk(input logic v, rw, ld, st, input logic [3:0] rd,
                                input logic [15:0] alu, sd, rdata, input int d);
    instr_t x;
    x.v = v; x.rw = rw; x.ld = ld; x.st = st; x.rd = rd;
    x.alu = alu; x.sd = sd; x.rdata = rdata; x.d = d;
    return x;
  endfunction

  // Single compare process: model compare, reset-value compare, and model pins.
  always @(negedge clk) begin
    if (check_mode == 1) begin
      checkOutput($sformatf("stall c%0d", cyc), 16'(stall), 16'(e_stall[cyc]));
      checkOutput($sformatf("mem_req c%0d", cyc), 16'(mem_req), 16'(e_req[cyc]));
      checkOutput($sformatf("mem_we c%0d", cyc), 16'(mem_we), 16'(e_we[cyc]));
      checkOutput($sformatf("RegWrite_out c%0d", cyc), 16'(RegWrite_out), 16'(e_rw[cyc]));
      checkOutput($sformatf("EX_MEM_reg_rd c%0d", cyc), 16'(EX_MEM_reg_rd), 16'(e_exmem[cyc]));
      checkOutput($sformatf("MEM_WB_reg_rd c%0d", cyc), 16'(MEM_WB_reg_rd), 16'(e_memwb[cyc]));
      checkOutput($sformatf("mem_err c%0d", cyc), 16'(mem_err), 16'(e_err[cyc]));
      if (e_req[cyc]) begin
        checkOutput($sformatf("mem_addr c%0d", cyc), mem_addr, e_addr[cyc]);
        checkOutput($sformatf("mem_wdata c%0d", cyc), mem_wdata, e_wdata[cyc]);
      end
      if (e_rw[cyc]) begin
        checkOutput($sformatf("reg_rd_wb c%0d", cyc), 16'(reg_rd_wb), 16'(e_rd[cyc]));
        checkOutput($sformatf("reg_rd_data c%0d", cyc), reg_rd_data, e_data[cyc]);
      end
      if (pin_model && cyc == 0) begin
        checkOutput("pin alu exmem c1", 16'(e_exmem[1]), 16'd3);
        checkOutput("pin alu rw c2", 16'(e_rw[2]), 16'd1);
        checkOutput("pin alu rd c2", 16'(e_rd[2]), 16'd3);
        checkOutput("pin alu data c2", e_data[2], 16'h1234);
        checkOutput("pin stall c1", 16'(e_stall[1]), 16'd0);
        checkOutput("pin stall c2", 16'(e_stall[2]), 16'd1);
        checkOutput("pin stall c3", 16'(e_stall[3]), 16'd1);
        checkOutput("pin stall c4", 16'(e_stall[4]), 16'd0);
        checkOutput("pin load addr c2", e_addr[2], 16'h0040);
        checkOutput("pin load data c5", e_data[5], 16'hBEEF);
        checkOutput("pin load rd c5", 16'(e_rd[5]), 16'd5);
        checkOutput("pin store we c5", 16'(e_we[5]), 16'd1);
        checkOutput("pin store addr c5", e_addr[5], 16'h0010);
        checkOutput("pin store wdata c5", e_wdata[5], 16'h00AA);
        checkOutput("pin store rw c6", 16'(e_rw[6]), 16'd0);
        checkOutput("pin r0 exmem c6", 16'(e_exmem[6]), 16'd0);
        checkOutput("pin r0 rw c7", 16'(e_rw[7]), 16'd0);
        checkOutput("pin tmo req c21", 16'(e_req[21]), 16'd1);
        checkOutput("pin tmo req c22", 16'(e_req[22]), 16'd0);
        checkOutput("pin tmo err c21", 16'(e_err[21]), 16'd0);
        checkOutput("pin tmo err c22", 16'(e_err[22]), 16'd1);
        checkOutput("pin after tmo data c24", e_data[24], 16'h5555);
      end
    end else if (check_mode == 2) begin
      checkOutput("reset stall", 16'(stall), 16'd0);
      checkOutput("reset mem_req", 16'(mem_req), 16'd0);
      checkOutput("reset mem_we", 16'(mem_we), 16'd0);
      checkOutput("reset mem_addr", mem_addr, 16'd0);
      checkOutput("reset mem_wdata", mem_wdata, 16'd0);
      checkOutput("reset RegWrite_out", 16'(RegWrite_out), 16'd0);
      checkOutput("reset reg_rd_wb", 16'(reg_rd_wb), 16'd0);
      checkOutput("reset reg_rd_data", reg_rd_data, 16'd0);
      checkOutput("reset EX_MEM_reg_rd", 16'(EX_MEM_reg_rd), 16'd0);
      checkOutput("reset MEM_WB_reg_rd", 16'(MEM_WB_reg_rd), 16'd0);
      checkOutput("reset mem_err", 16'(mem_err), 16'd0);
    end
  end

  initial begin
    // Directed: ALU op, 2-wait load, store, R0 write, timeout, then ALU op.
    doReset();
    prog.delete();
    prog.push_back(mk(1, 1, 0, 0, 4'd3, 16'h1234, 16'h0000, 16'h0000, 0));
    prog.push_back(mk(1, 1, 1, 0, 4'd5, 16'h0040, 16'h0000, 16'hBEEF, 2));
    prog.push_back(mk(1, 0, 0, 1, 4'd7, 16'h0010, 16'h00AA, 16'h0000, 0));
    prog.push_back(mk(1, 1, 0, 0, 4'd0, 16'hFFFF, 16'h0000, 16'h0000, 0));
    prog.push_back(mk(1, 1, 1, 0, 4'd9, 16'h1234, 16'h0000, 16'h0000, 15));
    prog.push_back(mk(1, 1, 0, 0, 4'd4, 16'h5555, 16'h0000, 16'h0000, 0));
    pin_model = 1'b1;
    runPhase();
    pin_model = 1'b0;

    // Randomized instruction stream, including back-to-back ops, ack on the last allowed cycle and timeouts.
    doReset();
    prog.delete();
    for (int i = 0; i < 90; i++) begin
      int kind;
      int dsel;
      kind = $urandom_range(0, 9);
      dsel = $urandom_range(0, 11);
      prog.push_back(mk(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                        (kind <= 3), (kind == 4 || kind == 5), 4'($urandom_range(0, 15)),
                        16'($urandom), 16'($urandom), 16'($urandom),
                        (dsel == 0) ? 15 : ((dsel == 1) ? 14 : $urandom_range(0, 3))));
    end
    runPhase();

    // Reset in the middle of an access, then an ALU op after release.
    doReset();
    prog.delete();
    prog.push_back(mk(1, 1, 1, 0, 4'd2, 16'h0777, 16'h0000, 16'h0000, 15));
    buildModel();
    for (int c = 0; c < 2; c++) begin
      cyc = c;
      applyStimulus(c);
      check_mode = 1;
      @(posedge clk); #1;
    end
    cyc = 2;
    applyStimulus(2);
    check_mode = 2;
    #1 rst = 1;
    @(posedge clk); #1;
    check_mode = 0;
    @(posedge clk); #1;
    rst = 0;
    prog.delete();
    prog.push_back(mk(1, 1, 0, 0, 4'd6, 16'h0BAD, 16'h0000, 16'h0000, 0));
    runPhase();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
